// File: rtl/rdma_scatter_sequencer.sv
// Splits one RDMA payload message into four equal segments, issuing a local write
// request per segment and then passing exactly that segment's beats downstream.
module rdma_scatter_sequencer #(
  parameter int VADDR_W = 48,
  parameter int LEN_W   = 28,
  parameter int PID_W   = 6,
  parameter int DATA_W  = 512
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [VADDR_W-1:0] cfg_vaddr_1,
  input  logic [VADDR_W-1:0] cfg_vaddr_2,
  input  logic [VADDR_W-1:0] cfg_vaddr_3,
  input  logic [VADDR_W-1:0] cfg_vaddr_4,
  input  logic               cfg_vaddr_valid,
  input  logic [LEN_W-1:0]   cfg_seg_len,
  input  logic [PID_W-1:0]   cfg_pid,
  input  logic [DATA_W-1:0]  s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  output logic [VADDR_W-1:0] m_req_vaddr,
  output logic [LEN_W-1:0]   m_req_len,
  output logic [PID_W-1:0]   m_req_pid,
  output logic               m_req_last,
  output logic               m_req_valid,
  input  logic               m_req_ready,
  output logic [DATA_W-1:0]  m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int             BEAT_B   = DATA_W / 8;
  localparam int             BEAT_SH  = $clog2(BEAT_B);
  localparam logic [LEN_W:0] BEAT_RND = (LEN_W+1)'(BEAT_B - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               err_q, err_d;
  logic               vld_q;
  logic [LEN_W-1:0]   seg_len_q;
  logic [LEN_W-1:0]   seg_beats_q;
  logic [PID_W-1:0]   pid_q;
  logic [VADDR_W-1:0] vaddr_q [4];
  logic [VADDR_W-1:0] cfg_vaddr [4];

  logic               arm;
  logic               latch_cfg;
  logic               in_req;
  logic               in_data;
  logic               beat_hs;
  logic               seg_end;
  logic               final_beat;
  logic [LEN_W:0]     len_round;
  logic [LEN_W-1:0]   seg_beats_calc;

  assign cfg_vaddr[0] = cfg_vaddr_1;
  assign cfg_vaddr[1] = cfg_vaddr_2;
  assign cfg_vaddr[2] = cfg_vaddr_3;
  assign cfg_vaddr[3] = cfg_vaddr_4;

  // Round up to whole beats; the extra bit keeps the carry of a near-max length.
  assign len_round      = {1'b0, cfg_seg_len} + BEAT_RND;
  assign seg_beats_calc = LEN_W'(len_round >> BEAT_SH);

  assign in_req     = (state_q == S_REQ);
  assign in_data    = (state_q == S_DATA);
  assign arm        = (state_q == S_IDLE) && cfg_vaddr_valid && !vld_q;
  assign beat_hs    = in_data && s_tvalid && m_tready;
  assign seg_end    = (beat_cnt_q == '0);
  assign final_beat = seg_end && (idx_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    latch_cfg  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          latch_cfg = 1'b1;
          idx_d     = 2'd0;
          err_d     = (cfg_seg_len == '0);
          if (cfg_seg_len != '0) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (m_req_ready) begin
          state_d    = S_DATA;
          beat_cnt_d = seg_beats_q - 1'b1;
        end
      end
      S_DATA: begin
        if (beat_hs) begin
          beat_cnt_d = beat_cnt_q - 1'b1;
          // A message end anywhere but the very last beat truncates the scatter.
          if (s_tlast && !final_beat) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (seg_end) begin
            if (idx_q == 2'd3) begin
              state_d = S_DONE;
              if (!s_tlast) begin
                err_d = 1'b1;
              end
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = S_REQ;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      vld_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      vld_q      <= cfg_vaddr_valid;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      seg_len_q   <= '0;
      seg_beats_q <= '0;
      pid_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        vaddr_q[i] <= '0;
      end
    end else if (latch_cfg) begin
      seg_len_q   <= cfg_seg_len;
      seg_beats_q <= seg_beats_calc;
      pid_q       <= cfg_pid;
      for (int i = 0; i < 4; i++) begin
        vaddr_q[i] <= cfg_vaddr[i];
      end
    end
  end

  // Request fields are forced to zero outside REQ so an idle block drives a quiet bus.
  assign m_req_valid = in_req;
  assign m_req_vaddr = in_req ? vaddr_q[idx_q] : '0;
  assign m_req_len   = in_req ? seg_len_q : '0;
  assign m_req_pid   = in_req ? pid_q : '0;
  assign m_req_last  = in_req && (idx_q == 2'd3);

  assign m_tvalid = in_data && s_tvalid;
  assign s_tready = in_data && m_tready;
  assign m_tdata  = in_data ? s_tdata : '0;
  assign m_tlast  = in_data && (seg_end || s_tlast);

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule
